// File: rtl/register_file_pkg.sv
// -----------------------------------------------------------------------------
// register_file_pkg
//   Constants shared between the register file, the write-address mux and
//   the control unit: datapath/index widths and the architecturally fixed
//   register indices (zero register and the jal link register).
// -----------------------------------------------------------------------------
package register_file_pkg;

   parameter int ADDR_W   = 5;
   parameter int DATA_W   = 32;
   parameter int NUM_REGS = 32;

   // $zero is hardwired; $ra is the link target of jal.
   parameter logic [ADDR_W-1:0] REG_ZERO = 5'd0;
   parameter logic [ADDR_W-1:0] REG_RA   = 5'd31;

endpackage : register_file_pkg

// File: rtl/register_file_if.sv
// -----------------------------------------------------------------------------
// register_file_if
//   Read/write bus of the general-purpose register file.
//   master : writeback path + decode (drives indices, write data, enable)
//   slave  : register file (returns the two source operands)
//   Signals:
//     ReadRegister1/2 : rs / rt indices
//     WriteRegister   : destination index from the write-address mux
//     WriteData       : writeback value
//     RegWrite        : write enable
//     ReadData1/2     : rs / rt operands to the ALU stage
// -----------------------------------------------------------------------------
interface register_file_if #(
   parameter int DATA_W = register_file_pkg::DATA_W,
   parameter int ADDR_W = register_file_pkg::ADDR_W
);

   logic [ADDR_W-1:0] ReadRegister1;
   logic [ADDR_W-1:0] ReadRegister2;
   logic [ADDR_W-1:0] WriteRegister;
   logic [DATA_W-1:0] WriteData;
   logic              RegWrite;
   logic [DATA_W-1:0] ReadData1;
   logic [DATA_W-1:0] ReadData2;

   modport master (
      output ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
      input  ReadData1, ReadData2
   );

   modport slave (
      input  ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
      output ReadData1, ReadData2
   );

endinterface : register_file_if

// File: rtl/register_file_read_port.sv
// -----------------------------------------------------------------------------
// register_file_read_port
//   One combinational read path: storage mux plus optional write-first bypass.
//   Instantiated once per source operand so both ports behave identically.
//   Ports:
//     rst_n_i  : active-low reset, forces the output to zero while low
//     regs_i   : flattened storage array
//     raddr_i  : read index
//     waddr_i  : write index of the current cycle
//     wdata_i  : write data of the current cycle
//     wen_i    : write enable already qualified with waddr_i != 0
//     rdata_o  : read data
// -----------------------------------------------------------------------------
module register_file_read_port #(
   parameter int DATA_W   = register_file_pkg::DATA_W,
   parameter int ADDR_W   = register_file_pkg::ADDR_W,
   parameter int NUM_REGS = register_file_pkg::NUM_REGS,
   parameter bit BYPASS   = 1'b1
) (
   input  logic                             rst_n_i,
   input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_i,
   input  logic [ADDR_W-1:0]                raddr_i,
   input  logic [ADDR_W-1:0]                waddr_i,
   input  logic [DATA_W-1:0]                wdata_i,
   input  logic                             wen_i,
   output logic [DATA_W-1:0]                rdata_o
);

   import register_file_pkg::*;

   logic hit;
   logic rd_zero;

   assign hit     = BYPASS && wen_i && (raddr_i == waddr_i);
   // The zero check also covers the bypass case, so $zero never leaks a
   // pending write value.
   assign rd_zero = !rst_n_i || (raddr_i == ADDR_W'(REG_ZERO));

   assign rdata_o = rd_zero ? '0 :
                    hit     ? wdata_i :
                              regs_i[raddr_i];

endmodule : register_file_read_port

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//   32 x 32-bit general-purpose register file for the single-cycle datapath.
//   Synchronous write on the rising Clk edge, combinational reads, register 0
//   hardwired to zero, optional write-first forwarding (BYPASS).
//   Ports:
//     Clk   : system clock
//     Rst_n : asynchronous active-low reset; clears every entry
//     rf    : register_file_if.slave (indices, write data/enable, operands)
// -----------------------------------------------------------------------------
module register_file #(
   parameter int DATA_W   = register_file_pkg::DATA_W,
   parameter int ADDR_W   = register_file_pkg::ADDR_W,
   parameter int NUM_REGS = register_file_pkg::NUM_REGS,
   parameter bit BYPASS   = 1'b1
) (
   input  logic            Clk,
   input  logic            Rst_n,
   register_file_if.slave  rf
);

   import register_file_pkg::*;

   // Every index must map to exactly one entry; anything else would leave
   // unreachable entries or out-of-range reads.
   if (NUM_REGS != (1 << ADDR_W)) begin : g_bad_cfg
      $error("register_file: NUM_REGS (%0d) must equal 2**ADDR_W (%0d)",
             NUM_REGS, 1 << ADDR_W);
   end

   logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
   logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;
   logic                            wen;

   assign wen = rf.RegWrite && (rf.WriteRegister != ADDR_W'(REG_ZERO));

   // Written as a select rather than an if so an X on RegWrite smears into
   // the addressed entry instead of silently holding the old value.
   always_comb begin
      regs_d = regs_q;
      for (int i = 1; i < NUM_REGS; i++) begin
         regs_d[i] = (wen && (rf.WriteRegister == ADDR_W'(i))) ? rf.WriteData
                                                                : regs_q[i];
      end
      regs_d[0] = '0;
   end

   // Reset is asynchronous, so an assertion coinciding with a write edge
   // always leaves the entry cleared.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         regs_q <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   register_file_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_REGS(NUM_REGS),
      .BYPASS  (BYPASS)
   ) u_rd1 (
      .rst_n_i(Rst_n),
      .regs_i (regs_q),
      .raddr_i(rf.ReadRegister1),
      .waddr_i(rf.WriteRegister),
      .wdata_i(rf.WriteData),
      .wen_i  (wen),
      .rdata_o(rf.ReadData1)
   );

   register_file_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_REGS(NUM_REGS),
      .BYPASS  (BYPASS)
   ) u_rd2 (
      .rst_n_i(Rst_n),
      .regs_i (regs_q),
      .raddr_i(rf.ReadRegister2),
      .waddr_i(rf.WriteRegister),
      .wdata_i(rf.WriteData),
      .wen_i  (wen),
      .rdata_o(rf.ReadData2)
   );

endmodule : register_file

// File: tb/tb_register_file.sv
`timescale 1ns/100ps
module tb_register_file;

   logic        clk;
   logic        rstn;
   logic [4:0]  ra1, ra2, wa;
   logic [31:0] wd;
   logic        we;

   int checks;
   int failures;

   // Reference: architectural register contents.
   logic [31:0] mdl [32];

   register_file_if #(.DATA_W(32), .ADDR_W(5)) if_b ();
   register_file_if #(.DATA_W(32), .ADDR_W(5)) if_n ();

   assign if_b.ReadRegister1 = ra1;
   assign if_b.ReadRegister2 = ra2;
   assign if_b.WriteRegister = wa;
   assign if_b.WriteData     = wd;
   assign if_b.RegWrite      = we;
   assign if_n.ReadRegister1 = ra1;
   assign if_n.ReadRegister2 = ra2;
   assign if_n.WriteRegister = wa;
   assign if_n.WriteData     = wd;
   assign if_n.RegWrite      = we;

   register_file #(.BYPASS(1'b1)) u_byp (.Clk(clk), .Rst_n(rstn), .rf(if_b.slave));
   register_file #(.BYPASS(1'b0)) u_nob (.Clk(clk), .Rst_n(rstn), .rf(if_n.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
      end
   endtask

   // Expected operand from the architectural rules.
   function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
      if (!rstn || ra == 5'd0) return 32'h0;
      if (byp && we && wa != 5'd0 && ra == wa) return wd;
      return mdl[ra];
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".b1"}, if_b.ReadData1, exp_rd(ra1, 1'b1));
      chk({tag, ".b2"}, if_b.ReadData2, exp_rd(ra2, 1'b1));
      chk({tag, ".n1"}, if_n.ReadData1, exp_rd(ra1, 1'b0));
      chk({tag, ".n2"}, if_n.ReadData2, exp_rd(ra2, 1'b0));
   endtask

   // Called right after a falling edge with inputs set: check pre-edge
   // values, clock once, update the model, return on the next falling edge.
   task automatic cycle(input string tag);
      #1;
      check_all(tag);
      @(posedge clk);
      if (rstn && we && wa != 5'd0) mdl[wa] = wd;
      @(negedge clk);
   endtask

   task automatic clear_mdl();
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
   endtask

   task automatic set(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] w,
                      input logic [31:0] d, input logic e);
      ra1 = r1; ra2 = r2; wa = w; wd = d; we = e;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      clear_mdl();
      rstn = 1'b0;
      set(5'd0, 5'd0, 5'd0, 32'h0, 1'b0);

      // Reset: reads return zero and writes (including bypass) are blocked,
      // across several clock edges.
      for (int i = 1; i < 32; i++) begin
         set(5'(i), 5'(i), 5'(i), $urandom, 1'b1);
         #1;
         check_all("rst_read");
      end
      we = 1'b0;
      @(negedge clk);
      rstn = 1'b1;

      // Basic write/read.
      set(5'd0, 5'd0, 5'd8, 32'hDEADBEEF, 1'b1); cycle("wr8");
      set(5'd0, 5'd0, 5'd9, 32'h00000005, 1'b1); cycle("wr9");
      set(5'd8, 5'd9, 5'd0, 32'h0, 1'b0);        cycle("rd89");
      chk("rd8_const", if_n.ReadData1, 32'hDEADBEEF);
      chk("rd9_const", if_n.ReadData2, 32'h00000005);

      // Register 0 immunity, during and after the edge.
      set(5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1); cycle("r0_wr");
      set(5'd0, 5'd0, 5'd0, 32'h0, 1'b0);        cycle("r0_after");

      // Bypass vs no-bypass.
      set(5'd0, 5'd0, 5'd10, 32'h1, 1'b1);         cycle("r10_init");
      set(5'd10, 5'd10, 5'd10, 32'hA5A5A5A5, 1'b1);
      #1;
      chk("byp_p1", if_b.ReadData1, 32'hA5A5A5A5);
      chk("byp_p2", if_b.ReadData2, 32'hA5A5A5A5);
      chk("nob_p1", if_n.ReadData1, 32'h1);
      chk("nob_p2", if_n.ReadData2, 32'h1);
      cycle("byp_cyc");
      set(5'd10, 5'd10, 5'd0, 32'h0, 1'b0);
      #1;
      chk("nob_after", if_n.ReadData1, 32'hA5A5A5A5);
      chk("byp_after", if_b.ReadData2, 32'hA5A5A5A5);
      cycle("r10_after");

      // Write disable holds the entry.
      for (int k = 0; k < 3; k++) begin
         set(5'd8, 5'd8, 5'd8, 32'h12345678, 1'b0);
         cycle("wdis");
      end
      chk("wdis_r8", if_b.ReadData1, 32'hDEADBEEF);

      // Randomised traffic; half the reads target the write index.
      for (int n = 0; n < 400; n++) begin
         logic [4:0] w;
         w = 5'($urandom_range(0, 31));
         set(($urandom_range(0, 1) != 0) ? w : 5'($urandom_range(0, 31)),
             ($urandom_range(0, 1) != 0) ? w : 5'($urandom_range(0, 31)),
             w, $urandom, 1'($urandom_range(0, 1)));
         cycle("rand");
      end

      // Fill 1..31 with their index, then an asynchronous reset pulse
      // between edges.
      for (int i = 1; i < 32; i++) begin
         set(5'd0, 5'd0, 5'(i), 32'(i), 1'b1);
         cycle("fill");
      end
      set(5'd5, 5'd31, 5'd0, 32'h0, 1'b0);
      #1;
      chk("fill_r5", if_b.ReadData1, 32'd5);
      chk("fill_r31", if_n.ReadData2, 32'd31);
      rstn = 1'b0;
      clear_mdl();
      #1;
      chk("arst_r5", if_b.ReadData1, 32'h0);
      chk("arst_r31", if_n.ReadData2, 32'h0);
      ra1 = 5'd17; ra2 = 5'd1;
      #1;
      check_all("arst_mid");
      #1;
      rstn = 1'b1;
      @(negedge clk);
      for (int i = 1; i < 32; i++) begin
         set(5'(i), 5'(32 - i), 5'd0, 32'h0, 1'b0);
         cycle("arst_post");
      end

      // Reset asserted on a write edge: reset wins.
      set(5'd12, 5'd12, 5'd12, 32'hCAFEF00D, 1'b1);
      #1;
      chk("coin_pre", if_b.ReadData1, 32'hCAFEF00D);
      @(posedge clk);
      rstn = 1'b0;
      clear_mdl();
      #1;
      check_all("coin_rst");
      @(negedge clk);
      rstn = 1'b1;
      set(5'd12, 5'd12, 5'd0, 32'h0, 1'b0);
      cycle("coin_post");
      chk("coin_r12", if_n.ReadData1, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_register_file

// File: doc/register_file.md
Name: register_file

Overview:
General-purpose register file for the single-cycle MIPS-style datapath. It sits directly downstream of the write-address mux: it consumes the selected 5-bit WriteRegister together with WriteData and RegWrite from the writeback path. It supplies the two source operands, rs and rt, to the ALU stage. Storage is 32 x 32-bit with a synchronous write and combinational read, and register 0 is hardwired to zero.

Parameters:
DATA_W, 32, width of each register and of the data ports
ADDR_W, 5, width of the register-index ports
NUM_REGS, 32, number of registers; must equal 2**ADDR_W
BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read port; 0 = reads return stored contents only

Ports:
Clk  input  1  system clock; all writes occur on the rising edge
Rst_n  input  1  asynchronous, active-low reset
ReadRegister1  input  ADDR_W  rs index
ReadRegister2  input  ADDR_W  rt index
WriteRegister  input  ADDR_W  destination index, driven by the write-address mux
WriteData  input  DATA_W  writeback value
RegWrite  input  1  write enable
ReadData1  output  DATA_W  contents of ReadRegister1
ReadData2  output  DATA_W  contents of ReadRegister2

Behaviour:
- Reset: Rst_n low clears all NUM_REGS entries to 0 immediately, independent of Clk. While Rst_n is low, writes are blocked and both read ports return 0.
- Reset deassertion: the first possible write lands on the first rising Clk edge on which Rst_n is high.
- Write: on a rising Clk edge with Rst_n high, RegWrite=1 and WriteRegister!=0, regs[WriteRegister] <= WriteData. Otherwise no entry changes.
- Register 0: writes to index 0 are silently discarded. Any read of index 0 returns 0, including under bypass.
- Read: ReadDataN is a combinational function of ReadRegisterN and storage, with zero-cycle latency. No read-side clocking.
- Bypass (BYPASS=1): if RegWrite=1, WriteRegister!=0 and ReadRegisterN==WriteRegister, then ReadDataN = WriteData in that same cycle (write-first). After the edge, storage holds the same value.
- No bypass (BYPASS=0): in that same cycle ReadDataN shows the old contents; the new value is visible only after the edge.
- Both ports may address the same register. They must then return identical values, with bypass applied independently per port.
- Indices are unsigned and no out-of-range index is possible when NUM_REGS=2**ADDR_W. An elaboration-time check must flag any other combination.
- Reset mid-operation: an assertion coinciding with a write edge wins, so the register ends at 0.
- X on RegWrite while Rst_n is high: the simulation model must propagate X into the addressed entry, not silently hold it.

Decomposition:
- Shared package: ADDR_W and DATA_W constants, plus named index constants REG_ZERO=0 and REG_RA=31 for the jal path, so that the write-address mux and the control unit share them.
- A separate sub-module is not required: the storage array, write logic and two identical read/bypass paths fit in one module.
- Optional: one read_port sub-module (mux plus bypass compare), instantiated twice to keep the two read paths provably identical.

Test Plan:
- Reset: hold Rst_n=0, then set ReadRegister1 and ReadRegister2 to each of 1..31 -> ReadData1 = ReadData2 = 0 for every index; release Rst_n.
- Basic write/read: write 32'hDEADBEEF to reg 8 and 32'h00000005 to reg 9 on consecutive edges, RegWrite=1; then ReadRegister1=8, ReadRegister2=9 -> 32'hDEADBEEF and 32'h00000005.
- R0 immunity: RegWrite=1, WriteRegister=0, WriteData=32'hFFFFFFFF, one edge; ReadRegister1=0 -> 0 both during and after the edge.
- Bypass: reg 10 holds 32'h1; in one cycle set WriteRegister=10, WriteData=32'hA5A5A5A5, RegWrite=1, ReadRegister1=ReadRegister2=10.
  - BYPASS=1 -> both ports show 32'hA5A5A5A5 before the edge.
  - BYPASS=0 -> both ports show 32'h1 before the edge and 32'hA5A5A5A5 after it.
- Write disable: RegWrite=0, WriteRegister=8, WriteData=32'h12345678, several edges -> reg 8 still reads 32'hDEADBEEF.
- Async reset mid-run: after filling regs 1..31 with their index value, pulse Rst_n low for 3 ns between clock edges -> all reads drop to 0 immediately, with no Clk edge required.
